// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit 5-stage pipeline: opcode map, register
// address width, sequencer state encoding and the pipeline control bundle.
package cpu_pkg;

    localparam int RA_W  = 4;
    localparam int OPC_W = 4;

    // Opcode field is instr[15:12]; only the ones the sequencer cares about
    // (through upstream decode) are listed here.
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OPC_W-1:0] OP_LW   = 4'h4;
    localparam logic [OPC_W-1:0] OP_SW   = 4'h5;
    localparam logic [OPC_W-1:0] OP_BEQ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h9;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'hA;
    localparam logic [OPC_W-1:0] OP_DIV  = 4'hB;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    // Sequencer states; the encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_MULDIV = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HALTED = 3'd3
    } seq_state_e;

    // Everything the sequencer drives into the pipeline registers.
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_flush;
        logic exmem_flush;
        logic alu_busy;
        logic halted;
    } pipe_ctl_t;

    // Free-running pipeline: every stage advances, nothing is killed.
    localparam pipe_ctl_t CTL_ADVANCE = '{
        pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_we: 1'b1,
        idex_flush: 1'b0, exmem_flush: 1'b0, alu_busy: 1'b0, halted: 1'b0
    };

    // Everything frozen and bubbled; used in reset and once halted.
    localparam pipe_ctl_t CTL_SAFE = '{
        pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1, idex_we: 1'b0,
        idex_flush: 1'b1, exmem_flush: 1'b1, alu_busy: 1'b0, halted: 1'b0
    };

    function automatic logic op_is_load(input logic [OPC_W-1:0] opc);
        return opc == OP_LW;
    endfunction

    function automatic logic op_is_muldiv(input logic [OPC_W-1:0] opc);
        return (opc == OP_MUL) || (opc == OP_DIV);
    endfunction

    function automatic logic op_is_halt(input logic [OPC_W-1:0] opc);
        return opc == OP_HALT;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// real instruction sitting in ID. Full-width compare, no register excluded.
module pipeline_sequencer_hazard #(
    parameter int RA_W = 4
) (
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            ex_valid,
    input  logic            ex_is_load,
    input  logic [RA_W-1:0] ex_rd,
    output logic            load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // Combinational compare of the EX destination against both ID sources.
    always_comb begin
        rs1_hit  = (ex_rd == id_rs1);
        rs2_hit  = (ex_rd == id_rs2);
        load_use = ex_valid & ex_is_load & id_valid & (rs1_hit | rs2_hit);
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush/halt controller for the IF-ID-EX-MEM-WB pipeline. Sole owner
// of the PC, IF/ID, ID/EX enables and the IF/ID, ID/EX, EX/MEM flushes.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  RUN    | normal issue; hazards resolved cycle by cycle
//  MULDIV | mul/div occupying EX; front end frozen, EX/MEM bubbled
//  DRAIN  | halt seen in ID; EX/MEM/WB retire, front end held
//  HALTED | pipeline empty and stopped; only rst leaves this state
module pipeline_sequencer #(
    parameter int MULDIV_CYCLES = 4,
    parameter int DRAIN_CYCLES  = 3,
    parameter int RA_W          = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_halt,
    input  logic            ex_valid,
    input  logic            ex_is_load,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_muldiv,
    input  logic            ex_redirect,
    output logic            pc_we,
    output logic            ifid_we,
    output logic            ifid_flush,
    output logic            idex_we,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            alu_busy,
    output logic            halted,
    output logic [2:0]      state
);

    import cpu_pkg::*;

    // Counter holds at most max(param)-1, so clog2(max) bits suffice.
    localparam int MAX_CNT = max_int(max_int(MULDIV_CYCLES, DRAIN_CYCLES), 2);
    localparam int CNT_W   = $clog2(MAX_CNT);

    // The entry cycle in RUN already counts as the first EX cycle of the
    // mul/div, and the release cycle at count==0 is the last one, hence -2.
    localparam bit             MD_STALL = (MULDIV_CYCLES > 1);
    localparam logic [CNT_W-1:0] MD_LOAD =
        CNT_W'((MULDIV_CYCLES > 1) ? (MULDIV_CYCLES - 2) : 0);
    localparam logic [CNT_W-1:0] DR_LOAD =
        CNT_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    pipe_ctl_t        ctl;
    logic             load_use;

    pipeline_sequencer_hazard #(
        .RA_W (RA_W)
    ) u_hazard (
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    // State and counter register; reset drops straight back to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and pipeline controls from state and hazards.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctl     = CTL_ADVANCE;

        case (state_q)
            ST_RUN: begin
                if (ex_valid && ex_muldiv && MD_STALL) begin
                    // Muldiv wins over a (nonsensical) redirect from the same op.
                    ctl.pc_we       = 1'b0;
                    ctl.ifid_we     = 1'b0;
                    ctl.idex_we     = 1'b0;
                    ctl.exmem_flush = 1'b1;
                    ctl.alu_busy    = 1'b1;
                    cnt_d           = MD_LOAD;
                    state_d         = ST_MULDIV;
                end else if (ex_redirect) begin
                    // IF and ID hold wrong-path instructions; their halt or
                    // load-use hazards are irrelevant.
                    ctl.ifid_flush = 1'b1;
                    ctl.idex_flush = 1'b1;
                end else if (load_use) begin
                    ctl.pc_we      = 1'b0;
                    ctl.ifid_we    = 1'b0;
                    ctl.idex_flush = 1'b1;
                end else if (id_valid && id_halt) begin
                    // Halt stays parked in ID and never reaches EX.
                    ctl.pc_we      = 1'b0;
                    ctl.ifid_we    = 1'b0;
                    ctl.idex_flush = 1'b1;
                    cnt_d          = DR_LOAD;
                    state_d        = ST_DRAIN;
                end
            end

            ST_MULDIV: begin
                if (cnt_q == '0) begin
                    // Result leaves EX this cycle; whole pipe advances.
                    state_d = ST_RUN;
                end else begin
                    ctl.pc_we       = 1'b0;
                    ctl.ifid_we     = 1'b0;
                    ctl.idex_we     = 1'b0;
                    ctl.exmem_flush = 1'b1;
                    ctl.alu_busy    = 1'b1;
                    cnt_d           = cnt_q - CNT_ONE;
                end
            end

            ST_DRAIN: begin
                ctl.pc_we      = 1'b0;
                ctl.ifid_we    = 1'b0;
                ctl.idex_flush = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_HALTED: begin
                ctl        = CTL_SAFE;
                ctl.halted = 1'b1;
            end

            default: begin
                ctl     = CTL_SAFE;
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        // While reset is held, nothing may load and every stage is bubbled.
        if (rst) begin
            ctl = CTL_SAFE;
        end
    end

    // Port fan-out of the control bundle and debug state.
    always_comb begin
        pc_we       = ctl.pc_we;
        ifid_we     = ctl.ifid_we;
        ifid_flush  = ctl.ifid_flush;
        idex_we     = ctl.idex_we;
        idex_flush  = ctl.idex_flush;
        exmem_flush = ctl.exmem_flush;
        alu_busy    = ctl.alu_busy;
        halted      = ctl.halted;
        state       = state_q;
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: reset, load-use, mul/div timing,
// redirect priority, halt/drain, reset out of MULDIV and DRAIN.
module tb_pipeline_sequencer;

    // Control vector bit order:
    // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, alu_busy, halted}
    localparam logic [7:0] V_NORM  = 8'b1101_0000;
    localparam logic [7:0] V_RST   = 8'b0010_1100;
    localparam logic [7:0] V_HALT  = 8'b0010_1101;
    localparam logic [7:0] V_STALL = 8'b0000_1000;  // load-use / drain
    localparam logic [7:0] M_STALL = 8'b1110_1111;  // idex_we don't-care under flush
    localparam logic [7:0] V_MD    = 8'b0000_0110;
    localparam logic [7:0] V_REDIR = 8'b1010_1000;
    localparam logic [7:0] M_REDIR = 8'b1010_1111;  // we's don't-care under flush
    localparam logic [7:0] M_ALL   = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_halt, ex_valid, ex_is_load, ex_muldiv, ex_redirect;
    logic [3:0] id_rs1, id_rs2, ex_rd;

    logic       pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, alu_busy, halted;
    logic [2:0] state;
    logic       pc_we1, ifid_we1, ifid_flush1, idex_we1, idex_flush1, exmem_flush1, alu_busy1, halted1;
    logic [2:0] state1;

    logic [7:0] ctl, ctl1;
    assign ctl  = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, alu_busy, halted};
    assign ctl1 = {pc_we1, ifid_we1, ifid_flush1, idex_we1, idex_flush1, exmem_flush1, alu_busy1, halted1};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_sequencer #(.MULDIV_CYCLES(4), .DRAIN_CYCLES(3), .RA_W(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_halt(id_halt), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_muldiv(ex_muldiv), .ex_redirect(ex_redirect), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .alu_busy(alu_busy), .halted(halted), .state(state)
    );

    pipeline_sequencer #(.MULDIV_CYCLES(1), .DRAIN_CYCLES(3), .RA_W(4)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_halt(id_halt), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_muldiv(ex_muldiv), .ex_redirect(ex_redirect), .pc_we(pc_we1), .ifid_we(ifid_we1),
        .ifid_flush(ifid_flush1), .idex_we(idex_we1), .idex_flush(idex_flush1),
        .exmem_flush(exmem_flush1), .alu_busy(alu_busy1), .halted(halted1), .state(state1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [7:0] exp, input logic [7:0] mask,
                           input logic [2:0] st);
        chk({tag, "_ctl"}, 32'(ctl & mask), 32'(exp & mask));
        chk({tag, "_state"}, 32'(state), 32'(st));
    endtask

    // Hazard-free traffic: real instructions in ID and EX, no dependencies.
    task automatic idle();
        id_valid = 1'b1; id_rs1 = 4'd1; id_rs2 = 4'd2; id_halt = 1'b0;
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 4'd7;
        ex_muldiv = 1'b0; ex_redirect = 1'b0;
    endtask

    task automatic load_use(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        idle();
        ex_is_load = 1'b1; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    endtask

    // Advance one clock; inputs are then changed at edge+1, sampled at edge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #2;
        chk_ctl("reset", V_RST, M_ALL, 3'd0);
        chk("reset_busy_m1", 32'(ctl1), 32'(V_RST));

        // Release and run
        tick(); rst = 1'b0; #1;
        chk_ctl("run", V_NORM, M_ALL, 3'd0);

        // Reset asserted mid-run takes effect in the same cycle
        tick(); rst = 1'b1; #1;
        chk_ctl("rst_midrun", V_RST, M_ALL, 3'd0);
        tick(); rst = 1'b0; #1;
        chk_ctl("rst_release", V_NORM, M_ALL, 3'd0);

        // Load-use on rs1: one bubble, then normal
        tick(); load_use(4'd3, 4'd3, 4'd0); #1;
        chk_ctl("lu_rs1", V_STALL, M_STALL, 3'd0);
        tick(); idle(); ex_valid = 1'b0; #1;
        chk_ctl("lu_after", V_NORM, M_ALL, 3'd0);

        // Load-use on rs2 only
        tick(); load_use(4'd3, 4'd5, 4'd3); #1;
        chk_ctl("lu_rs2", V_STALL, M_STALL, 3'd0);

        // Load rd=3, rs1=5, rs2=4: no dependency
        tick(); load_use(4'd3, 4'd5, 4'd4); #1;
        chk_ctl("lu_none", V_NORM, M_ALL, 3'd0);

        // Register 0 and 15 are compared like any other
        tick(); load_use(4'd0, 4'd0, 4'd9); #1;
        chk_ctl("lu_r0", V_STALL, M_STALL, 3'd0);
        tick(); load_use(4'd15, 4'd8, 4'd15); #1;
        chk_ctl("lu_r15", V_STALL, M_STALL, 3'd0);

        // Matching regs but ID is a bubble, or EX not a load: no stall
        tick(); load_use(4'd3, 4'd3, 4'd3); id_valid = 1'b0; #1;
        chk_ctl("lu_idbubble", V_NORM, M_ALL, 3'd0);
        tick(); load_use(4'd3, 4'd3, 4'd3); ex_is_load = 1'b0; #1;
        chk_ctl("lu_notload", V_NORM, M_ALL, 3'd0);

        // Mul/div: 3 busy cycles, release on the 4th; MULDIV_CYCLES=1 never stalls
        tick(); idle(); ex_muldiv = 1'b1; #1;
        chk_ctl("md_c0", V_MD, M_ALL, 3'd0);
        chk("md1_c0", 32'(ctl1), 32'(V_NORM));
        chk("md1_c0_state", 32'(state1), 32'd0);
        // Other inputs are ignored while the mul/div owns EX
        tick(); load_use(4'd3, 4'd3, 4'd3); ex_redirect = 1'b1; id_halt = 1'b1; #1;
        chk_ctl("md_c1", V_MD, M_ALL, 3'd1);
        tick(); idle(); #1;
        chk_ctl("md_c2", V_MD, M_ALL, 3'd1);
        tick(); #1;
        chk_ctl("md_c3", V_NORM, M_ALL, 3'd1);
        tick(); #1;
        chk_ctl("md_done", V_NORM, M_ALL, 3'd0);

        // Muldiv together with redirect: muldiv wins
        tick(); idle(); ex_muldiv = 1'b1; ex_redirect = 1'b1; #1;
        chk_ctl("md_vs_redir", V_MD, M_ALL, 3'd0);
        // Reset in the middle of MULDIV returns to RUN with a cleared counter
        tick(); idle(); #1;
        chk_ctl("md_rst_pre", V_MD, M_ALL, 3'd1);
        rst = 1'b1; #1;
        chk_ctl("md_rst", V_RST, M_ALL, 3'd0);
        tick(); rst = 1'b0; #1;
        chk_ctl("md_rst_rel", V_NORM, M_ALL, 3'd0);

        // Redirect beats both halt and load-use in ID
        tick(); load_use(4'd3, 4'd3, 4'd0); id_halt = 1'b1; ex_redirect = 1'b1; #1;
        chk_ctl("redir", V_REDIR, M_REDIR, 3'd0);
        tick(); idle(); #1;
        chk_ctl("redir_after", V_NORM, M_ALL, 3'd0);

        // Halt: 3 DRAIN cycles, then HALTED for good
        tick(); idle(); id_halt = 1'b1; #1;
        chk_ctl("halt_c0", V_STALL, M_STALL, 3'd0);
        for (int i = 1; i <= 3; i++) begin
            tick(); #1;
            chk_ctl($sformatf("drain_c%0d", i), V_STALL, M_STALL, 3'd2);
        end
        tick(); #1;
        chk_ctl("halted_c4", V_HALT, M_ALL, 3'd3);
        tick(); idle(); ex_redirect = 1'b1; ex_muldiv = 1'b1; #1;
        chk_ctl("halted_c5", V_HALT, M_ALL, 3'd3);
        tick(); idle(); #1;
        chk_ctl("halted_c6", V_HALT, M_ALL, 3'd3);
        rst = 1'b1; #1;
        chk_ctl("halted_rst", V_RST, M_ALL, 3'd0);
        tick(); rst = 1'b0; #1;
        chk_ctl("halted_rel", V_NORM, M_ALL, 3'd0);

        // Reset during DRAIN, then a fresh halt still drains for the full 3 cycles
        tick(); id_halt = 1'b1; #1;
        chk_ctl("halt2_c0", V_STALL, M_STALL, 3'd0);
        tick(); #1;
        chk_ctl("halt2_c1", V_STALL, M_STALL, 3'd2);
        rst = 1'b1; #1;
        chk_ctl("drain_rst", V_RST, M_ALL, 3'd0);
        tick(); rst = 1'b0; idle(); #1;
        chk_ctl("drain_rel", V_NORM, M_ALL, 3'd0);
        tick(); id_halt = 1'b1; #1;
        chk_ctl("halt3_c0", V_STALL, M_STALL, 3'd0);
        for (int i = 1; i <= 3; i++) begin
            tick(); #1;
            chk_ctl($sformatf("drain3_c%0d", i), V_STALL, M_STALL, 3'd2);
        end
        tick(); #1;
        chk_ctl("halted3", V_HALT, M_ALL, 3'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
